// File: rtl/fp_mult_pipeline.sv
// Streaming FP32 multiplier: one a*b per clock, result five edges later.
// DAZ/FTZ, round-to-nearest-even, canonical quiet NaN.
package fp_mult_pkg;

  typedef struct packed {
    logic sgn;
    logic nan;
    logic inf;
    logic zero;
  } cls_t;

  typedef struct packed {
    cls_t        c;
    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [23:0] ma;
    logic [23:0] mb;
  } s1_t;

  typedef struct packed {
    cls_t               c;
    logic signed [9:0]  exp;
    logic [47:0]        prod;
  } s2_t;

  typedef struct packed {
    cls_t               c;
    logic signed [9:0]  exp;
    logic [22:0]        frac;
    logic               grd;
    logic               stk;
  } s3_t;

  typedef struct packed {
    cls_t               c;
    logic signed [9:0]  exp;
    logic [22:0]        frac;
  } s4_t;

endpackage

module fp_mult_pipeline
  import fp_mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        valid_in,
  output logic [31:0] result,
  output logic        valid_out
);

  logic        v0, v1, v2, v3, v4;
  logic [31:0] a0, b0;
  s1_t         s1, s1_d;
  s2_t         s2, s2_d;
  s3_t         s3, s3_d;
  s4_t         s4, s4_d;
  logic [31:0] pack_d;

  logic [7:0]  ea0, eb0;
  logic        a_max, b_max;
  logic        a_nul, b_nul;
  logic        a_frc, b_frc;
  logic        a_nan, b_nan;
  logic        a_inf, b_inf;

  assign ea0   = a0[30:23];
  assign eb0   = b0[30:23];
  assign a_max = &ea0;
  assign b_max = &eb0;
  assign a_nul = ~|ea0;
  assign b_nul = ~|eb0;
  assign a_frc = |a0[22:0];
  assign b_frc = |b0[22:0];
  assign a_nan = a_max & a_frc;
  assign b_nan = b_max & b_frc;
  assign a_inf = a_max & ~a_frc;
  assign b_inf = b_max & ~b_frc;

  // Subnormals classify as zero, so inf * subnormal is NaN too.
  always_comb begin
    s1_d        = '0;
    s1_d.c.sgn  = a0[31] ^ b0[31];
    s1_d.c.nan  = a_nan | b_nan
                | (a_inf & b_nul)
                | (b_inf & a_nul);
    s1_d.c.inf  = a_inf | b_inf;
    s1_d.c.zero = a_nul | b_nul;
    s1_d.ea     = ea0;
    s1_d.eb     = eb0;
    s1_d.ma     = {1'b1, a0[22:0]};
    s1_d.mb     = {1'b1, b0[22:0]};
  end

  always_comb begin
    s2_d      = '0;
    s2_d.c    = s1.c;
    s2_d.exp  = {2'b00, s1.ea}
              + {2'b00, s1.eb}
              - 10'd127;
    s2_d.prod = {24'd0, s1.ma}
              * {24'd0, s1.mb};
  end

  logic hi;
  assign hi = s2.prod[47];

  always_comb begin
    s3_d      = '0;
    s3_d.c    = s2.c;
    s3_d.exp  = s2.exp + {9'd0, hi};
    s3_d.frac = hi ? s2.prod[46:24]
                   : s2.prod[45:23];
    s3_d.grd  = hi ? s2.prod[23]
                   : s2.prod[22];
    s3_d.stk  = hi ? |s2.prod[22:0]
                   : |s2.prod[21:0];
  end

  logic        rnd;
  logic [23:0] rsum;

  assign rnd  = s3.grd & (s3.stk | s3.frac[0]);
  assign rsum = {1'b0, s3.frac} + {23'd0, rnd};

  // A carry out of the fraction leaves it zero and bumps the exponent.
  always_comb begin
    s4_d      = '0;
    s4_d.c    = s3.c;
    s4_d.exp  = s3.exp + {9'd0, rsum[23]};
    s4_d.frac = rsum[22:0];
  end

  logic ovf, unf;
  assign ovf = $signed(s4.exp) >= 10'sd255;
  assign unf = $signed(s4.exp) <= 10'sd0;

  always_comb begin
    pack_d = {s4.c.sgn, s4.exp[7:0], s4.frac};
    if (s4.c.nan)
      pack_d = 32'h7FC0_0000;
    else if (s4.c.inf)
      pack_d = {s4.c.sgn, 8'hFF, 23'd0};
    else if (s4.c.zero)
      pack_d = {s4.c.sgn, 31'd0};
    else if (ovf)
      pack_d = {s4.c.sgn, 8'hFF, 23'd0};
    else if (unf)
      pack_d = {s4.c.sgn, 31'd0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      a0        <= '0;
      b0        <= '0;
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      s4        <= '0;
      result    <= '0;
      valid_out <= 1'b0;
    end else begin
      v0        <= valid_in;
      v1        <= v0;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      a0        <= a;
      b0        <= b;
      s1        <= s1_d;
      s2        <= s2_d;
      s3        <= s3_d;
      s4        <= s4_d;
      valid_out <= v4;
      if (v4)
        result <= pack_d;
    end
  end

endmodule

// File: tb/tb_fp_mult_pipeline.sv
// Bench for fp_mult_pipeline: directed table, timing/reset sequences,
// and random ops scored against a real-arithmetic reference.
module tb_fp_mult_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        valid_in;
  logic [31:0] result;
  logic        valid_out;

  fp_mult_pipeline dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .result    (result),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  typedef struct {
    logic [31:0] y;
    int          iss;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)",
               nm, act, req, $time);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp_val(input logic [31:0] x);
    real f = real'(x[22:0]) / 8388608.0;
    return (1.0 + f) * pow2(int'(x[30:23]) - 127);
  endfunction

  // Exact product in double, then RNE to 24 bits and range checks.
  function automatic logic [31:0] ref_mul(input logic [31:0] x,
                                          input logic [31:0] y);
    logic s;
    logic xn, yn, xi, yi, xz, yz;
    real  p, fr, fl, rem;
    int   e, be, n;
    s  = x[31] ^ y[31];
    xz = (x[30:23] == 8'h00);
    yz = (y[30:23] == 8'h00);
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    if (xn || yn || (xi && yz) || (yi && xz))
      return 32'h7FC0_0000;
    if (xi || yi) return {s, 8'hFF, 23'd0};
    if (xz || yz) return {s, 31'd0};
    p = fp_val(x) * fp_val(y);
    e = 0;
    while (p >= 2.0) begin p = p / 2.0; e++; end
    while (p < 1.0)  begin p = p * 2.0; e--; end
    fr  = p * 8388608.0;
    fl  = $floor(fr);
    rem = fr - fl;
    n   = $rtoi(fl);
    if (rem > 0.5 || (rem == 0.5 && (n % 2) == 1)) n++;
    if (n == 16777216) begin n = 8388608; e++; end
    be = e + 127;
    if (be >= 255) return {s, 8'hFF, 23'd0};
    if (be <= 0)   return {s, 31'd0};
    return {s, be[7:0], n[22:0]};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [31:0] x;
    int k;
    k = $urandom_range(0, 19);
    x = $urandom;
    if (k == 0)
      x[30:0] = '0;
    else if (k == 1)
      x[30:0] = {8'hFF, 23'd0};
    else if (k == 2) begin
      x[30:23] = 8'hFF;
      x[0]     = 1'b1;
    end else if (k == 3)
      x[30:23] = 8'h00;
    else if (k == 4) begin
      x[30:23] = 8'($urandom_range(1, 254));
      x[22:0]  = '0;
    end else if (k < 12)
      x[30:23] = 8'($urandom_range(1, 254));
    else
      x[30:23] = 8'($urandom_range(100, 154));
    return x;
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [31:0] xa,
                       input logic [31:0] xb,
                       input logic [31:0] xe);
    exp_t t;
    a        = xa;
    b        = xb;
    valid_in = 1'b1;
    t.y      = xe;
    t.iss    = cyc + 1;
    q.push_back(t);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  // Scoreboard: order, value and exact 5-edge latency of every output.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (valid_out) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stray_valid: result %h with nothing pending",
                 result);
      end else begin
        e = q.pop_front();
        chk("stream_result", result, e.y);
        n_cmp++;
        if (cyc != e.iss + 5) begin
          n_bad++;
          $display("FAIL latency: got %0d edges want 5",
                   cyc - e.iss);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  vec_t tab[12];

  initial begin
    int w;
    logic [31:0] x, y;

    tab[0]  = '{32'h3F800000, 32'h40000000, 32'h40000000};
    tab[1]  = '{32'h40000000, 32'h40400000, 32'h40C00000};
    tab[2]  = '{32'hBF800000, 32'hC0000000, 32'h40000000};
    tab[3]  = '{32'h3EAAAAAB, 32'h40000000, 32'h3F2AAAAB};
    tab[4]  = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000};
    tab[5]  = '{32'h00000000, 32'h7F800000, 32'h7FC00000};
    tab[6]  = '{32'h7F800000, 32'hBF800000, 32'hFF800000};
    tab[7]  = '{32'h80000000, 32'h3F800000, 32'h80000000};
    tab[8]  = '{32'h7F000000, 32'h7F000000, 32'h7F800000};
    tab[9]  = '{32'h00800000, 32'h00800000, 32'h00000000};
    tab[10] = '{32'h33800000, 32'h33800000, 32'h27800000};
    tab[11] = '{32'h47000000, 32'h38000000, 32'h3F800000};

    rst      = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    #3;
    chk("reset_result", result, 32'h0);
    chk("reset_valid", {31'd0, valid_out}, 32'h0);
    tick(2);
    rst = 1'b1;
    tick(2);

    for (int i = 0; i < 12; i++)
      issue(tab[i].a, tab[i].b, tab[i].y);
    tick(8);

    issue(32'h3F800000, 32'h40400000, 32'h40400000);
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("lat_idle", {31'd0, valid_out}, 32'h0);
    end
    tick(1);
    chk("lat_valid", {31'd0, valid_out}, 32'h1);
    chk("lat_result", result, 32'h40400000);
    tick(1);
    chk("hold_valid", {31'd0, valid_out}, 32'h0);
    chk("hold_result", result, 32'h40400000);
    tick(3);

    issue(32'h3F800000, 32'h3F800000, 32'h3F800000);
    issue(32'h40000000, 32'h40000000, 32'h40800000);
    issue(32'hC0400000, 32'h40000000, 32'hC0C00000);
    issue(32'h3F000000, 32'h3F000000, 32'h3E800000);
    issue(32'h41200000, 32'h41200000, 32'h42C80000);
    tick(8);

    issue(32'h40000000, 32'h40400000, 32'h40C00000);
    issue(32'h3F800000, 32'h40000000, 32'h40000000);
    issue(32'h41200000, 32'h40000000, 32'h41A00000);
    tick(1);
    #1;
    rst = 1'b0;
    q.delete();
    #1;
    chk("midrst_result", result, 32'h0);
    chk("midrst_valid", {31'd0, valid_out}, 32'h0);
    tick(3);
    rst = 1'b1;
    tick(10);
    issue(32'h40400000, 32'h40400000, 32'h41100000);
    tick(8);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        x = rand_fp();
        y = rand_fp();
        issue(x, y, ref_mul(x, y));
      end else begin
        tick(1);
      end
    end

    w = 0;
    while (q.size() != 0 && w < 20) begin
      tick(1);
      w++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d results pending want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
